fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue -- sequential-PC instruction fetcher feeding a DEPTH-entry FIFO
//                with redirect flush; 1-cycle-latency ROM interface.
// Revision: 1.0
// ============================================================================
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  input  logic                    redirect_valid,
  input  logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [DATA_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]      w_used;
  logic                  w_req;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_unused_pc_lsbs;

  // Slots already claimed include the response still in flight, so a
  // returning response always finds room at the tail.
  assign w_used  = count_q + CNT_W'(inflight_q);
  assign w_req   = !rst && !redirect_valid && (w_used < CNT_W'(DEPTH));
  assign w_valid = !rst && (count_q != '0);
  assign w_pop   = w_valid && out_ready;
  assign w_push  = inflight_q && !redirect_valid;

  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_req  = w_req;
  assign imem_addr = rst ? RESET_PC : fetch_pc_q;
  assign out_valid = w_valid;
  assign out_instr = instr_q[head_q];
  assign out_pc    = pc_q[head_q];
  assign occupancy = rst ? '0 : count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (w_push) tail_d = tail_q + PTR_W'(1);
      if (w_pop)  head_d = head_q + PTR_W'(1);
      count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      inflight_d = w_req;
      if (w_req) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + DATA_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      instr_q[tail_q] <= imem_rdata;
      pc_q[tail_q]    <= inflight_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue -- vector table, directed corner sequences and random
//                   traffic against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [2:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction ROM: one-cycle read latency, garbage when not requested.
  always @(posedge clk)
    imem_rdata <= imem_req ? rom(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_occ;
  } vec_t;

  typedef struct {
    logic [31:0] instr, pc;
  } entry_t;

  // Reference model: the queue as a plain SV queue plus one pending fetch.
  logic [31:0] m_fpc = RESET_PC;
  entry_t      m_q[$];
  bit          m_infl = 1'b0;
  logic [31:0] m_ipc  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask

  task automatic check_model();
    int  sz    = m_q.size();
    bit  e_req = !rst && !redirect_valid && (sz + int'(m_infl) < DEPTH);
    bit  e_val = !rst && sz > 0;
    chk("req",   32'(imem_req),  32'(e_req));
    chk("addr",  imem_addr,      rst ? RESET_PC : m_fpc);
    chk("valid", 32'(out_valid), 32'(e_val));
    chk("occ",   32'(occupancy), rst ? 32'd0 : 32'(sz));
    if (e_val) begin
      chk("out_pc",    out_pc,    m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
  endtask

  task automatic advance();
    bit req = !rst && !redirect_valid && (m_q.size() + int'(m_infl) < DEPTH);
    if (rst) begin
      m_q.delete(); m_infl = 0; m_fpc = RESET_PC;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete(); m_infl = 0; m_fpc = redirect_pc & ~32'h3;
      end else begin
        if (m_infl) m_q.push_back('{rom(m_ipc), m_ipc});
        m_infl = req;
        m_ipc  = m_fpc;
        if (req) m_fpc = m_fpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    drive(r, rv, rpc, rdy);
    check_model();
  endtask

  vec_t tbl[18];

  initial begin
    // Reset, streaming fill, a 4-cycle stall, release, then a redirect to 0x103.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00,  1'b0, 32'h00,  0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h00,  1'b0, 32'h00,  0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h04,  1'b0, 32'h00,  0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h08,  1'b1, 32'h00,  1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0C,  1'b1, 32'h04,  1};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b1, 32'h08,  1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h08,  2};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h18,  1'b1, 32'h08,  3};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h18,  1'b1, 32'h08,  4};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h18,  1'b1, 32'h08,  4};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'h0C,  3};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h10,  2};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b1, 32'h14,  2};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h24,  1'b1, 32'h18,  2};
    tbl[14] = '{1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h28,  1'b1, 32'h1C,  2};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h00,  0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h00,  0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk("tbl_req",   32'(imem_req),  32'(tbl[i].e_req));
      chk("tbl_addr",  imem_addr,      tbl[i].e_addr);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_valid));
      chk("tbl_occ",   32'(occupancy), 32'(tbl[i].e_occ));
      if (tbl[i].e_valid) begin
        chk("tbl_pc",    out_pc,    tbl[i].e_pc);
        chk("tbl_instr", out_instr, rom(tbl[i].e_pc));
      end
      advance();
    end

    // Redirect with three entries queued and one fetch in flight.
    cyc(1, 0, 0, 0); advance();
    for (int i = 0; i < 4; i++) begin cyc(0, 0, 0, 0); advance(); end
    cyc(0, 0, 0, 0); chk("pre_redirect_occ", 32'(occupancy), 32'd3);
    chk("pre_redirect_infl_blocks_req", 32'(imem_req), 32'd0);
    drive(0, 1, 32'h103, 0); check_model(); advance();
    cyc(0, 0, 0, 0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_addr", imem_addr, 32'h100);
    advance();
    cyc(0, 0, 0, 0); advance();
    cyc(0, 0, 0, 0); chk("flush_first_pc", out_pc, 32'h100); advance();

    // Back-to-back redirects: only the second target is fetched.
    for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 1); advance(); end
    cyc(0, 1, 32'h40, 1); advance();
    cyc(0, 1, 32'h80, 1); chk("b2b_no_req", 32'(imem_req), 32'd0); advance();
    cyc(0, 0, 0, 1); chk("b2b_addr", imem_addr, 32'h80); advance();
    cyc(0, 0, 0, 1); advance();
    cyc(0, 0, 0, 1); chk("b2b_out_pc", out_pc, 32'h80); advance();

    // Address wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFF8, 1); advance();
    cyc(0, 0, 0, 1); chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8); advance();
    cyc(0, 0, 0, 1); chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC); advance();
    cyc(0, 0, 0, 1); chk("wrap_addr2", imem_addr, 32'h0);
    chk("wrap_out0", out_pc, 32'hFFFF_FFF8); advance();
    cyc(0, 0, 0, 1); chk("wrap_out1", out_pc, 32'hFFFF_FFFC); advance();
    cyc(0, 0, 0, 1); chk("wrap_out2", out_pc, 32'h0); advance();

    // Reset pulse while full.
    for (int i = 0; i < 6; i++) begin cyc(0, 0, 0, 0); advance(); end
    cyc(0, 0, 0, 0); chk("full_occ", 32'(occupancy), 32'd4); advance();
    cyc(1, 0, 0, 0); advance();
    cyc(0, 0, 0, 1);
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_occ",   32'(occupancy), 32'd0);
    chk("rst_full_addr",  imem_addr, RESET_PC);
    chk("rst_full_req",   32'(imem_req), 32'd1);
    advance();

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(199) == 0);
      rv  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(9) < 7);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
      cyc(r, rv, rpc, rdy);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
